pll_mdrp_seq: RTL

- Run-time reconfiguration sequencer for a Gowin PLLA dynamic-reconfiguration (MDRP) port.
- Holds a table of NUM_MODES register sets, e.g. 27 MHz/480p and 74.25 MHz/720p pixel clocks.
- On request, holds the PLL in reset, writes one mode's register set over MDRP, releases reset, then waits for lock with a timeout.
- Sits between the video mode-select logic and the PLL wrapper; runs on the same clock that drives the MDRP clock input.

---
 rtl/pll_mdrp_pkg.sv | 41 ++++
 rtl/lock_sync.sv | 31 +++
 rtl/pll_mdrp_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pll_mdrp_pkg.sv
// Shared types and constants for the PLLA MDRP reconfiguration sequencer.
package pll_mdrp_pkg;

  // Sequencer states; the read-back states are only reachable with PLL_MDRP_VERIFY_EN.
  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StData,
    StGap,
    StRaddr,
    StRwait,
    StRchk,
    StHold,
    StWaitLock,
    StDone,
    StErr
  } state_e;

  // MDRP opcodes.
  localparam logic [1:0] OPC_NOP   = 2'b00;
  localparam logic [1:0] OPC_WRITE = 2'b01;
  localparam logic [1:0] OPC_READ  = 2'b10;

  // Table entry layout: {addr[7:0], data[7:0]}.
  localparam int unsigned ENTRY_W        = 16;
  localparam int unsigned ENTRY_ADDR_LSB = 8;
  localparam int unsigned ENTRY_DATA_LSB = 0;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic logic [7:0] entry_addr(input logic [ENTRY_W-1:0] ent);
    return ent[ENTRY_ADDR_LSB +: 8];
  endfunction

  function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] ent);
    return ent[ENTRY_DATA_LSB +: 8];
  endfunction

endpackage

// File: rtl/lock_sync.sv
// lock_sync: two-flop synchroniser for an asynchronous PLL lock level.
module lock_sync (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next state: shift the raw level through two stages.
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchronous active-low reset clears both stages.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_mdrp_seq.sv
// pll_mdrp_seq: holds a PLLA in reset, writes one mode's register set over MDRP, releases
// reset and waits for lock with a timeout.
// Build option PLL_MDRP_VERIFY_EN: each register is read back after writing and a
// mismatch aborts the sequence with err.
module pll_mdrp_seq
  import pll_mdrp_pkg::*;
#(
  parameter int unsigned NUM_MODES     = 2,
  parameter int unsigned REGS_PER_MODE = 8,
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1048576,
  parameter int unsigned MODE_W        = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                                        clk,
  input  logic                                        resetn,
  input  logic [NUM_MODES*REGS_PER_MODE*ENTRY_W-1:0]  mode_tbl,
  input  logic                                        req,
  input  logic [MODE_W-1:0]                           mode_sel,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        err,
  output logic [MODE_W-1:0]                           cur_mode,
  output logic                                        locked,
  output logic                                        pll_reset,
  input  logic                                        pll_lock,
  output logic [1:0]                                  md_opc,
  output logic                                        md_ainc,
  output logic [7:0]                                  md_wdi,
  input  logic [7:0]                                  md_rdo
);

  localparam int unsigned NumEnt = NUM_MODES * REGS_PER_MODE;
  localparam int unsigned IdxW   = clog2_min1(REGS_PER_MODE);
  localparam int unsigned RstW   = clog2_min1(RESET_CYCLES);
  localparam int unsigned TmoW   = clog2_min1(LOCK_TIMEOUT);

  localparam logic [IdxW-1:0] IdxLast = IdxW'(REGS_PER_MODE - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
  localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);
  localparam logic [RstW-1:0] RstOne  = RstW'(1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(LOCK_TIMEOUT - 1);
  localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);

  state_e            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [MODE_W-1:0] cur_mode_q, cur_mode_d;
  logic              pll_reset_q, pll_reset_d;
  logic [1:0]        md_opc_q, md_opc_d;
  logic [7:0]        md_wdi_q, md_wdi_d;

  logic [ENTRY_W-1:0] start_ent, cur_ent, next_ent;
  logic               mode_ok;
  logic               rst_full;
  logic [RstW-1:0]    rst_inc;
  logic               reg_end;

  // Out-of-range indices fold to entry 0 so a bad mode_sel never reads past the table.
  function automatic logic [ENTRY_W-1:0] entry_at(input logic [MODE_W-1:0] m,
                                                   input logic [IdxW-1:0]   i);
    int unsigned e;
    e = 32'(m) * REGS_PER_MODE + 32'(i);
    if (e >= NumEnt) e = 0;
    return mode_tbl[e*ENTRY_W +: ENTRY_W];
  endfunction

  lock_sync u_lock_sync (
    .clk_i    (clk),
    .resetn_i (resetn),
    .d_i      (pll_lock),
    .q_o      (locked)
  );

  assign start_ent = entry_at(mode_sel, '0);
  assign cur_ent   = entry_at(mode_q, idx_q);
  assign next_ent  = entry_at(mode_q, idx_q + IdxOne);
  assign mode_ok   = (32'(mode_sel) < NUM_MODES);
  // rst_cnt_q counts completed high cycles minus one; saturates once the minimum is met.
  assign rst_full  = (rst_cnt_q == RstLast);
  assign rst_inc   = rst_full ? rst_cnt_q : rst_cnt_q + RstOne;

`ifndef PLL_MDRP_VERIFY_EN
  logic unused_rdo;
  assign unused_rdo = ^md_rdo;
`endif

  // Next-state and registered-output logic; outputs describe the state being entered.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    rst_cnt_d   = rst_cnt_q;
    tmo_d       = tmo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cur_mode_d  = cur_mode_q;
    pll_reset_d = pll_reset_q;
    md_opc_d    = OPC_NOP;
    md_wdi_d    = '0;
    reg_end     = 1'b0;

    if (pll_reset_q) rst_cnt_d = rst_inc;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (mode_ok) begin
            state_d     = StAddr;
            mode_d      = mode_sel;
            idx_d       = '0;
            rst_cnt_d   = '0;
            err_d       = 1'b0;
            busy_d      = 1'b1;
            pll_reset_d = 1'b1;
            md_opc_d    = OPC_WRITE;
            md_wdi_d    = entry_addr(start_ent);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAddr: begin
        state_d  = StData;
        md_wdi_d = entry_data(cur_ent);
      end
`ifdef PLL_MDRP_VERIFY_EN
      StData: begin
        state_d  = StRaddr;
        md_opc_d = OPC_READ;
        md_wdi_d = entry_addr(cur_ent);
      end
      StRaddr: state_d = StRwait;
      StRwait: state_d = StRchk;
      StRchk: begin
        if (md_rdo != entry_data(cur_ent)) begin
          state_d     = StErr;
          err_d       = 1'b1;
          busy_d      = 1'b0;
          pll_reset_d = 1'b0;
        end else begin
          reg_end = 1'b1;
        end
      end
`else
      StData: state_d = StGap;
      StGap:  reg_end = 1'b1;
`endif
      StHold: begin
        if (rst_full) begin
          state_d     = StWaitLock;
          pll_reset_d = 1'b0;
          tmo_d       = '0;
        end
      end
      StWaitLock: begin
        if (locked) begin
          state_d    = StDone;
          done_d     = 1'b1;
          cur_mode_d = mode_q;
          busy_d     = 1'b0;
        end else if (tmo_q == TmoLast) begin
          state_d     = StErr;
          err_d       = 1'b1;
          busy_d      = 1'b0;
          pll_reset_d = 1'b0;
        end else begin
          tmo_d = tmo_q + TmoOne;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // End of one register: next register, or skip HOLD when reset has been high long enough.
    if (reg_end) begin
      if (idx_q != IdxLast) begin
        state_d  = StAddr;
        idx_d    = idx_q + IdxOne;
        md_opc_d = OPC_WRITE;
        md_wdi_d = entry_addr(next_ent);
      end else if (rst_full) begin
        state_d     = StWaitLock;
        pll_reset_d = 1'b0;
        tmo_d       = '0;
      end else begin
        state_d = StHold;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      idx_q       <= '0;
      rst_cnt_q   <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cur_mode_q  <= '0;
      pll_reset_q <= 1'b0;
      md_opc_q    <= OPC_NOP;
      md_wdi_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cur_mode_q  <= cur_mode_d;
      pll_reset_q <= pll_reset_d;
      md_opc_q    <= md_opc_d;
      md_wdi_q    <= md_wdi_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cur_mode  = cur_mode_q;
  assign pll_reset = pll_reset_q;
  assign md_opc    = md_opc_q;
  assign md_ainc   = 1'b0;
  assign md_wdi    = md_wdi_q;

endmodule
